tinycpu_outport_capture: RTL and testbench

//   Host-side reader for the tinycpu output port. Captures every word the CPU

---
 rtl/tinycpu_outport_capture.sv | 167 ++++++++++++++++
 tb/tb_tinycpu_outport_capture.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinycpu_outport_capture.sv
// -----------------------------------------------------------------------------
// tinycpu_outport_capture
//
// Purpose:
//   Host-side reader for the tinycpu output port. Every word the CPU writes to
//   its output register (qualified by out_we) is captured into a small FIFO
//   together with a free-running cycle timestamp. A host or bench drains the
//   FIFO through a show-ahead valid/ready read port.
//
// Ports:
//   clk       in   1        system clock, all logic on the rising edge
//   reset     in   1        synchronous, active-high reset
//   out_we    in   1        CPU output-write strobe, one word per high cycle
//   out_data  in   WIDTH    CPU output word, sampled when out_we=1
//   rd_ready  in   1        host accepts the head word this cycle
//   rd_valid  out  1        FIFO non-empty, head word presented
//   rd_data   out  WIDTH    head word data (show-ahead)
//   rd_stamp  out  TSW      head word capture timestamp
//   count     out  AW+1     entries held, 0..DEPTH
//   full      out  1        count == DEPTH
//   empty     out  1        count == 0
//   overflow  out  1        sticky, a write was dropped
//   clr_ovf   in   1        clears overflow
//
// Read handshake:
//   A word transfers on a rising edge where rd_valid=1 and rd_ready=1. The
//   head (rd_data/rd_stamp) only changes after such a transfer or after a
//   push into an empty FIFO, so it is stable while rd_valid=1 and
//   rd_ready=0. rd_valid never depends combinationally on rd_ready, and
//   rd_ready while empty has no effect.
// -----------------------------------------------------------------------------
module tinycpu_outport_capture #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int TSW   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             out_we,
   input  logic [WIDTH-1:0] out_data,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [TSW-1:0]   rd_stamp,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   input  logic             clr_ovf
);

   // Each stored entry is {data, timestamp}.
   localparam int EW = WIDTH + TSW;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q,  count_d;
   logic [TSW-1:0] cyc_q,    cyc_d;
   logic           ovf_q,    ovf_d;

   // Storage is not reset; only the pointers and count define what is live.
   logic [EW-1:0]  mem_q [DEPTH];

   // ---------------------------------------------------------------------
   // Decoded flags, straight from the registered count
   // ---------------------------------------------------------------------
   logic full_w;
   logic empty_w;

   assign full_w  = (count_q == FULL_COUNT);
   assign empty_w = (count_q == '0);

   // ---------------------------------------------------------------------
   // Push / pop qualification
   // ---------------------------------------------------------------------
   logic          pop_w;
   logic          push_w;
   logic          drop_w;
   logic [EW-1:0] wr_word_w;

   // A pop frees a slot in the same edge, so a full FIFO can still accept
   // a write when the host is draining the head at the same time.
   assign pop_w     = rd_ready && !empty_w;
   assign push_w    = out_we && (!full_w || pop_w);
   assign drop_w    = out_we && full_w && !pop_w;
   assign wr_word_w = {out_data, cyc_q};

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cyc_d    = cyc_q + 1'b1;   // free-running, wraps silently
      ovf_d    = ovf_q;

      if (push_w) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Simultaneous push and pop leave the count unchanged.
      if (push_w && !pop_w) begin
         count_d = count_q + 1'b1;
      end else if (pop_w && !push_w) begin
         count_d = count_q - 1'b1;
      end

      // Clear first, so a drop in the same cycle keeps the flag set.
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (drop_w) begin
         ovf_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cyc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cyc_q    <= cyc_d;
         ovf_q    <= ovf_d;
      end
   end

   // Reset also blocks the memory write so nothing from a reset cycle
   // lands in storage.
   always_ff @(posedge clk) begin
      if (!reset && push_w) begin
         mem_q[wr_ptr_q] <= wr_word_w;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   logic [EW-1:0] head_w;

   assign head_w   = mem_q[rd_ptr_q];
   assign rd_data  = head_w[EW-1:TSW];
   assign rd_stamp = head_w[TSW-1:0];
   assign rd_valid = !empty_w;
   assign count    = count_q;
   assign full     = full_w;
   assign empty    = empty_w;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_tinycpu_outport_capture.sv
// -----------------------------------------------------------------------------
// tb_tinycpu_outport_capture
//
// Directed bench for the output-port capture FIFO. Inputs change on the
// falling edge; outputs are compared on the falling edge, half a cycle after
// the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_tinycpu_outport_capture;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int TSW   = 16;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             reset;
   logic             out_we;
   logic [WIDTH-1:0] out_data;
   logic             rd_ready;
   logic             clr_ovf;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic [TSW-1:0]   rd_stamp;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             overflow;

   always #5 clk = ~clk;

   // Reference cycle counter: zero in the first cycle after reset,
   // increments every cycle. Read on the falling edge it equals the
   // timestamp a write in that cycle must carry.
   logic [TSW-1:0] ref_cyc;
   always @(posedge clk) begin
      if (reset) ref_cyc <= '0;
      else       ref_cyc <= ref_cyc + 1'b1;
   end

   int vectors    = 0;
   int miscompares = 0;

   tinycpu_outport_capture #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .TSW(TSW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .out_we   (out_we),
      .out_data (out_data),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_stamp (rd_stamp),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      out_we   = 1'b0;
      out_data = '0;
      rd_ready = 1'b0;
      clr_ovf  = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // 1: reset held two cycles with writes requested
   // ---------------------------------------------------------------------
   task automatic test_reset();
      reset    = 1'b1;
      out_we   = 1'b1;
      out_data = 16'hAAAA;
      rd_ready = 1'b0;
      clr_ovf  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      idle_inputs();
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      tick();
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_nothing_captured: count %0d want 0", count); end
   endtask

   // ---------------------------------------------------------------------
   // 2: single write, empty-pop ignored, empty + write + ready
   // ---------------------------------------------------------------------
   task automatic test_single_write();
      logic [TSW-1:0] exp_stamp;
      out_we    = 1'b1;
      out_data  = 16'h000A;
      exp_stamp = ref_cyc;
      tick();
      idle_inputs();
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL single_rd_valid: got %b want 1", rd_valid); end
      vectors++; if (rd_data !== 16'h000A) begin miscompares++; $display("FAIL single_rd_data: got %h want 000a", rd_data); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count); end
      vectors++; if (rd_stamp !== exp_stamp) begin miscompares++; $display("FAIL single_rd_stamp: got %h want %h", rd_stamp, exp_stamp); end
      // Held while not accepted.
      tick();
      vectors++; if (rd_data !== 16'h000A) begin miscompares++; $display("FAIL single_hold: got %h want 000a", rd_data); end
      rd_ready = 1'b1;
      tick();
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty: got %b want 1", empty); end
      // rd_ready while empty must not underflow.
      tick();
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_ready_ignored: count %0d want 0", count); end
      // Empty + write + ready: push only, visible next cycle.
      out_we   = 1'b1;
      out_data = 16'h000B;
      tick();
      idle_inputs();
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL empty_push_ready_count: got %0d want 1", count); end
      vectors++; if (rd_data !== 16'h000B) begin miscompares++; $display("FAIL empty_push_ready_data: got %h want 000b", rd_data); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // 3: fill past full, overflow, clear/set collision, drain
   // ---------------------------------------------------------------------
   task automatic test_fill_overflow();
      logic [TSW-1:0] stamps [9];
      logic [TSW-1:0] prev;
      for (int i = 0; i < 9; i++) begin
         out_we    = 1'b1;
         out_data  = WIDTH'(i + 1);
         stamps[i] = ref_cyc;
         tick();
      end
      idle_inputs();
      vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d want 8", count); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow: got %b want 1", overflow); end
      // Drop and clear in the same cycle: the flag stays set.
      out_we   = 1'b1;
      out_data = 16'h00EE;
      clr_ovf  = 1'b1;
      tick();
      idle_inputs();
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL drop_count: got %0d want 8", count); end
      prev = '0;
      for (int i = 0; i < 8; i++) begin
         vectors++; if (rd_data !== WIDTH'(i + 1)) begin miscompares++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, WIDTH'(i + 1)); end
         vectors++; if (rd_stamp !== stamps[i]) begin miscompares++; $display("FAIL drain_stamp[%0d]: got %h want %h", i, rd_stamp, stamps[i]); end
         if (i > 0) begin
            vectors++; if (!(rd_stamp > prev)) begin miscompares++; $display("FAIL drain_stamp_increasing[%0d]: got %h after %h", i, rd_stamp, prev); end
         end
         prev     = rd_stamp;
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %b want 0", overflow); end
   endtask

   // ---------------------------------------------------------------------
   // 4: full with simultaneous write and read
   // ---------------------------------------------------------------------
   task automatic test_full_simultaneous();
      logic [WIDTH-1:0] exp_q [$];
      for (int i = 0; i < 8; i++) begin
         out_we   = 1'b1;
         out_data = WIDTH'(16'h0010 + i);
         exp_q.push_back(WIDTH'(16'h0010 + i));
         tick();
      end
      out_we   = 1'b1;
      out_data = 16'h0063;
      rd_ready = 1'b1;
      void'(exp_q.pop_front());
      exp_q.push_back(16'h0063);
      tick();
      idle_inputs();
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_simul_count: got %0d want 8", count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_simul_overflow: got %b want 0", overflow); end
      while (exp_q.size() > 0) begin
         vectors++; if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL full_simul_drain: got %h want %h", rd_data, exp_q[0]); end
         void'(exp_q.pop_front());
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL full_simul_empty: got %b want 1", empty); end
   endtask

   // ---------------------------------------------------------------------
   // 5: pointer wrap with interleaved traffic, then timestamp wrap
   // ---------------------------------------------------------------------
   task automatic test_wrap_around();
      logic [WIDTH-1:0] exp_q [$];
      int               occ;
      int               budget;
      occ = 0;
      for (int i = 0; i < 20; i++) begin
         rd_ready = (occ >= 2);
         if (rd_ready) begin
            vectors++; if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_data, exp_q[0]); end
            void'(exp_q.pop_front());
            occ--;
         end
         out_we   = 1'b1;
         out_data = WIDTH'(16'h0100 + i);
         exp_q.push_back(WIDTH'(16'h0100 + i));
         occ++;
         tick();
         vectors++; if (count !== 4'(occ)) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, occ); end
      end
      idle_inputs();
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         vectors++; if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL wrap_tail: got %h want %h", rd_data, exp_q[0]); end
         void'(exp_q.pop_front());
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
         budget++;
      end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end

      // Run the clock up to the last counter value before the wrap.
      budget = 0;
      while (ref_cyc != 16'hFFFF && budget < 70000) begin
         tick();
         budget++;
      end
      vectors++;
      if (ref_cyc != 16'hFFFF) begin
         miscompares++;
         $display("FAIL stamp_wrap_timeout: counter %h want ffff", ref_cyc);
      end
      out_we   = 1'b1;
      out_data = 16'h0AA1;
      tick();
      out_data = 16'h0AA2;
      tick();
      idle_inputs();
      vectors++; if (rd_stamp !== 16'hFFFF) begin miscompares++; $display("FAIL stamp_before_wrap: got %h want ffff", rd_stamp); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      vectors++; if (rd_data !== 16'h0AA2) begin miscompares++; $display("FAIL stamp_wrap_data: got %h want 0aa2", rd_data); end
      vectors++; if (rd_stamp !== 16'h0000) begin miscompares++; $display("FAIL stamp_after_wrap: got %h want 0000", rd_stamp); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // 6: reset with entries held and traffic active
   // ---------------------------------------------------------------------
   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         out_we   = 1'b1;
         out_data = WIDTH'(16'h0050 + i);
         tick();
      end
      idle_inputs();
      vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL mid_pre_count: got %0d want 5", count); end
      reset    = 1'b1;
      out_we   = 1'b1;
      out_data = 16'h0BAD;
      rd_ready = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL mid_reset_empty: got %b want 1", empty); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL mid_reset_count: got %0d want 0", count); end
      // First cycle after reset: counter is 0, so this word carries stamp 0.
      out_we   = 1'b1;
      out_data = 16'h0007;
      tick();
      idle_inputs();
      vectors++; if (rd_data !== 16'h0007) begin miscompares++; $display("FAIL mid_first_word: got %h want 0007", rd_data); end
      vectors++; if (rd_stamp !== 16'h0000) begin miscompares++; $display("FAIL mid_first_stamp: got %h want 0000", rd_stamp); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL mid_first_count: got %0d want 1", count); end
   endtask

   // ---------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single_write();
      test_fill_overflow();
      test_full_simultaneous();
      test_wrap_around();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
